// File: rtl/spike_aer_arbiter_pkg.sv
// Shared definitions for the spiking-neuron array and its AER arbiter.
package snn_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } arb_state_e;

  localparam int SNN_NUM_NEURONS = 16;

  typedef logic [$clog2(SNN_NUM_NEURONS)-1:0] aer_addr_t;

endpackage

// File: rtl/spike_aer_arbiter_if.sv
// AER output channel: address plus valid/ready handshake toward the routing fabric.
interface spike_aer_arbiter_if
  import snn_pkg::*;
#(
  parameter int NUM_NEURONS = SNN_NUM_NEURONS
);
  localparam int ADDR_W = $clog2(NUM_NEURONS);

  logic              aer_valid_o;
  logic              aer_ready_i;
  logic [ADDR_W-1:0] aer_addr_o;

  modport master (
    output aer_valid_o,
    output aer_addr_o,
    input  aer_ready_i
  );

  modport slave (
    input  aer_valid_o,
    input  aer_addr_o,
    output aer_ready_i
  );

endinterface

// File: rtl/spike_aer_arbiter_rr_pick.sv
// Circular priority encoder: first set request at or after ptr_i, wrapping at NUM_NEURONS-1.
module rr_pick
  import snn_pkg::*;
#(
  parameter int NUM_NEURONS = SNN_NUM_NEURONS
) (
  input  logic [NUM_NEURONS-1:0]         req_i,
  input  logic [$clog2(NUM_NEURONS)-1:0] ptr_i,
  output logic [$clog2(NUM_NEURONS)-1:0] grant_o,
  output logic                           any_o
);
  localparam int ADDR_W = $clog2(NUM_NEURONS);

  // One extra bit so ptr+i never overflows before the modulo fold (ptr < N, i < N).
  logic [ADDR_W:0]   sum;
  logic [ADDR_W-1:0] idx;

  always_comb begin
    grant_o = '0;
    any_o   = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      sum = {1'b0, ptr_i} + (ADDR_W+1)'(i);
      if (sum >= (ADDR_W+1)'(NUM_NEURONS)) begin
        sum = sum - (ADDR_W+1)'(NUM_NEURONS);
      end
      idx = sum[ADDR_W-1:0];
      if (!any_o && req_i[idx]) begin
        grant_o = idx;
        any_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spike_aer_arbiter.sv
// Round-robin AER arbiter: captures a spike vector per timestep and emits one address per handshake.
//   state | meaning
//   IDLE  | waiting for step_i; empty steps complete immediately
//   DRAIN | emitting captured spikes, aer_valid_o high
module spike_aer_arbiter
  import snn_pkg::*;
#(
  parameter int NUM_NEURONS = SNN_NUM_NEURONS
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_NEURONS-1:0] spike_i,
  input  logic                   step_i,
  spike_aer_arbiter_if.master    aer,
  output logic                   busy_o,
  output logic                   step_done_o,
  output logic                   overrun_o
);
  localparam int ADDR_W = $clog2(NUM_NEURONS);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_NEURONS - 1);

  arb_state_e             state_r, state_n;
  logic [NUM_NEURONS-1:0] pending_r, pending_n;
  logic [ADDR_W-1:0]      ptr_r, ptr_n;
  logic [ADDR_W-1:0]      grant;
  logic                   any_req;
  logic                   done_n, overrun_n;
  logic                   in_drain, hs;

  rr_pick #(
    .NUM_NEURONS(NUM_NEURONS)
  ) u_rr_pick (
    .req_i  (pending_r),
    .ptr_i  (ptr_r),
    .grant_o(grant),
    .any_o  (any_req)
  );

  assign in_drain        = (state_r == DRAIN);
  assign hs              = in_drain && aer.aer_ready_i && any_req;
  assign aer.aer_valid_o = in_drain;
  assign aer.aer_addr_o  = in_drain ? grant : '0;
  assign busy_o          = in_drain;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= IDLE;
      pending_r   <= '0;
      ptr_r       <= '0;
      step_done_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      state_r     <= state_n;
      pending_r   <= pending_n;
      ptr_r       <= ptr_n;
      step_done_o <= done_n;
      overrun_o   <= overrun_n;
    end
  end

  always_comb begin
    state_n   = state_r;
    pending_n = pending_r;
    ptr_n     = ptr_r;
    done_n    = 1'b0;
    overrun_n = 1'b0;
    unique case (state_r)
      IDLE: begin
        if (step_i) begin
          if (spike_i != '0) begin
            pending_n = spike_i;
            state_n   = DRAIN;
          end else begin
            done_n = 1'b1;
          end
        end
      end
      DRAIN: begin
        // A step landing here is dropped, even on the final handshake cycle.
        if (step_i) begin
          overrun_n = 1'b1;
        end
        if (hs) begin
          pending_n[grant] = 1'b0;
          ptr_n = (grant == LAST_IDX) ? '0 : grant + 1'b1;
          if (pending_n == '0) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spike_aer_arbiter.sv
// Self-checking bench for spike_aer_arbiter: directed scenarios plus a randomized run against a behavioural model.
module tb_spike_aer_arbiter;
  localparam int N = 16;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  spike;
  logic          step;
  logic          busy, done, ovr;

  int checks = 0;
  int errors = 0;

  // Behavioural model: pending set, fairness pointer, busy flag, pulse outputs.
  bit [N-1:0] m_pend;
  int         m_ptr;
  bit         m_busy, m_done, m_ovr;

  spike_aer_arbiter_if #(.NUM_NEURONS(N)) aer ();

  spike_aer_arbiter #(.NUM_NEURONS(N)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .spike_i    (spike),
    .step_i     (step),
    .aer        (aer.master),
    .busy_o     (busy),
    .step_done_o(done),
    .overrun_o  (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pick(bit [N-1:0] p, int ptr);
    for (int i = 0; i < N; i++) begin
      if (p[(ptr + i) % N]) return (ptr + i) % N;
    end
    return 0;
  endfunction

  function automatic logic [3:0] exp_addr();
    return m_busy ? 4'(pick(m_pend, m_ptr)) : 4'd0;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_ptr = 0; m_busy = 0; m_done = 0; m_ovr = 0;
  endtask

  // Advance one clock, applying the spec rules to the model with the inputs held across the edge.
  task automatic tick();
    bit [N-1:0] np;
    int g, nptr;
    bit nb, nd, no;
    np = m_pend; nptr = m_ptr; nb = m_busy; nd = 0; no = 0;
    g = pick(m_pend, m_ptr);
    if (!m_busy) begin
      if (step) begin
        if (spike != '0) begin np = spike; nb = 1; end
        else nd = 1;
      end
    end else begin
      if (step) no = 1;
      if (aer.aer_ready_i) begin
        np[g] = 1'b0;
        nptr  = (g + 1) % N;
        if (np == '0) begin nb = 0; nd = 1; end
      end
    end
    @(posedge clk);
    m_pend = np; m_ptr = nptr; m_busy = nb; m_done = nd; m_ovr = no;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; step = 1'b0; spike = '0; aer.aer_ready_i = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({aer.aer_valid_o, aer.aer_addr_o, busy, done, ovr} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b addr=%0d busy=%b done=%b ovr=%b, expected all 0",
               aer.aer_valid_o, aer.aer_addr_o, busy, done, ovr);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_empty_step();
    step = 1'b1; spike = '0; aer.aer_ready_i = 1'b1;
    tick();
    step = 1'b0;
    checks++;
    if (done !== 1'b1 || aer.aer_valid_o !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL empty_step: got done=%b valid=%b busy=%b, expected 1 0 0", done, aer.aer_valid_o, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL empty_step_pulse: got done=%b busy=%b, expected 0 0", done, busy);
    end
  endtask

  task automatic test_burst();
    logic [3:0] exp_seq [4] = '{4'd0, 4'd5, 4'd10, 4'd15};
    step = 1'b1; spike = 16'h8421; aer.aer_ready_i = 1'b1;
    tick();
    step = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (aer.aer_valid_o !== 1'b1 || aer.aer_addr_o !== exp_seq[i] || done !== 1'b0) begin
        errors++;
        $display("FAIL burst_addr[%0d]: got valid=%b addr=%0d done=%b, expected 1 %0d 0",
                 i, aer.aer_valid_o, aer.aer_addr_o, done, exp_seq[i]);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || aer.aer_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL burst_done: got done=%b valid=%b, expected 1 0", done, aer.aer_valid_o);
    end
    tick();
  endtask

  task automatic test_fairness();
    aer.aer_ready_i = 1'b1;
    step = 1'b1; spike = 16'h0003;
    tick();
    step = 1'b0;
    checks++;
    if (aer.aer_addr_o !== 4'd0) begin
      errors++; $display("FAIL fair_s1_a: got addr=%0d, expected 0", aer.aer_addr_o);
    end
    tick();
    checks++;
    if (aer.aer_addr_o !== 4'd1) begin
      errors++; $display("FAIL fair_s1_b: got addr=%0d, expected 1", aer.aer_addr_o);
    end
    tick();
    tick();
    step = 1'b1; spike = 16'h0005;
    tick();
    step = 1'b0;
    checks++;
    if (aer.aer_addr_o !== 4'd2) begin
      errors++; $display("FAIL fair_s2_a: got addr=%0d, expected 2", aer.aer_addr_o);
    end
    tick();
    checks++;
    if (aer.aer_addr_o !== 4'd0 || aer.aer_valid_o !== 1'b1) begin
      errors++; $display("FAIL fair_s2_wrap: got addr=%0d valid=%b, expected 0 1", aer.aer_addr_o, aer.aer_valid_o);
    end
    tick();
    tick();
  endtask

  task automatic test_backpressure();
    aer.aer_ready_i = 1'b0;
    step = 1'b1; spike = 16'h0030;
    tick();
    step = 1'b0;
    spike = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (aer.aer_valid_o !== 1'b1 || aer.aer_addr_o !== 4'd4) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got valid=%b addr=%0d, expected 1 4", i, aer.aer_valid_o, aer.aer_addr_o);
      end
      if (i == 2) aer.aer_ready_i = 1'b1;
      tick();
    end
    checks++;
    if (aer.aer_valid_o !== 1'b1 || aer.aer_addr_o !== 4'd5) begin
      errors++; $display("FAIL bp_next: got valid=%b addr=%0d, expected 1 5", aer.aer_valid_o, aer.aer_addr_o);
    end
    tick();
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL bp_done: got done=%b, expected 1", done);
    end
    spike = '0;
    tick();
  endtask

  task automatic test_overrun();
    // Pointer sits at 6 here, so 0x0111 drains 8, 0, 4.
    aer.aer_ready_i = 1'b1;
    step = 1'b1; spike = 16'h0111;
    tick();
    checks++;
    if (aer.aer_addr_o !== 4'd8 || ovr !== 1'b0) begin
      errors++; $display("FAIL ovr_first: got addr=%0d ovr=%b, expected 8 0", aer.aer_addr_o, ovr);
    end
    spike = 16'hFFFF;
    tick();
    step = 1'b0;
    checks++;
    if (ovr !== 1'b1 || aer.aer_addr_o !== 4'd0) begin
      errors++; $display("FAIL ovr_mid: got ovr=%b addr=%0d, expected 1 0", ovr, aer.aer_addr_o);
    end
    tick();
    checks++;
    if (ovr !== 1'b0 || aer.aer_addr_o !== 4'd4) begin
      errors++; $display("FAIL ovr_pulse_width: got ovr=%b addr=%0d, expected 0 4", ovr, aer.aer_addr_o);
    end
    step = 1'b1;
    tick();
    step = 1'b0;
    checks++;
    if (ovr !== 1'b1 || done !== 1'b1 || aer.aer_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL ovr_final_hs: got ovr=%b done=%b valid=%b, expected 1 1 0", ovr, done, aer.aer_valid_o);
    end
    tick();
    checks++;
    if (ovr !== 1'b0 || done !== 1'b0 || aer.aer_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL ovr_after: got ovr=%b done=%b valid=%b, expected 0 0 0", ovr, done, aer.aer_valid_o);
    end
    spike = '0;
  endtask

  task automatic test_reset_mid_drain();
    aer.aer_ready_i = 1'b1;
    step = 1'b1; spike = 16'hFFFF;
    tick();
    step = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (aer.aer_valid_o !== 1'b0 || busy !== 1'b0 || aer.aer_addr_o !== 4'd0) begin
      errors++;
      $display("FAIL rst_async: got valid=%b busy=%b addr=%0d, expected 0 0 0", aer.aer_valid_o, busy, aer.aer_addr_o);
    end
    model_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL rst_no_done[%0d]: got done=%b busy=%b, expected 0 0", i, done, busy);
      end
    end
    step = 1'b1; spike = 16'h8001;
    tick();
    step = 1'b0;
    checks++;
    if (aer.aer_addr_o !== 4'd0) begin
      errors++; $display("FAIL rst_ptr_cleared: got addr=%0d, expected 0", aer.aer_addr_o);
    end
    tick();
    tick();
    tick();
  endtask

  task automatic test_random();
    logic [7:0] got, exp;
    for (int c = 0; c < 600; c++) begin
      step  = ($urandom_range(0, 3) == 0);
      spike = ($urandom_range(0, 4) == 0) ? '0 : N'($urandom);
      aer.aer_ready_i = ($urandom_range(0, 3) != 0);
      tick();
      got = {aer.aer_valid_o, aer.aer_addr_o, busy, done, ovr};
      exp = {m_busy, exp_addr(), m_busy, m_done, m_ovr};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random[%0d]: got {valid,addr,busy,done,ovr}=%b expected %b", c, got, exp);
      end
    end
    step = 1'b0;
  endtask

  initial begin
    test_reset();
    test_empty_step();
    test_burst();
    test_fairness();
    test_backpressure();
    test_overrun();
    test_reset_mid_drain();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spike_aer_arbiter.md
# spike_aer_arbiter

Round-robin scheduler that shares one address-event (AER) output channel among the neuron array. On each timestep strobe it captures every neuron's `spike_o` and drains the set one address per handshake, starting after the last neuron served. It signals completion of the step and flags strobes that arrive before draining finishes. It sits between the neuron array and the downstream synapse/routing fabric.

## Interface
- `NUM_NEURONS`, default 16: number of spike inputs; must be 2 or more.
- `ADDR_W`, default `$clog2(NUM_NEURONS)`: width of the address output; derived, never overridden.
- `clk_i`  in  1  single clock, rising edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `spike_i`  in  NUM_NEURONS  per-neuron spike level; bit k comes from neuron k.
- `step_i`  in  1  timestep strobe, one cycle wide; samples `spike_i`.
- `aer_valid_o`  out  1  `aer_addr_o` holds a pending spike.
- `aer_ready_i`  in  1  downstream accepts the address.
- `aer_addr_o`  out  ADDR_W  index of the neuron being emitted.
- `busy_o`  out  1  high while in DRAIN.
- `step_done_o`  out  1  one-cycle pulse when the captured step is fully drained.
- `overrun_o`  out  1  one-cycle pulse when `step_i` arrives while busy.

## Operation
- State: FSM {IDLE, DRAIN}; `pending_r[NUM_NEURONS]`; round-robin pointer `ptr_r[ADDR_W]`.
- Reset: state=IDLE, `pending_r`=0, `ptr_r`=0, `step_done_o`=0, `overrun_o`=0. This forces `aer_valid_o`=0, `aer_addr_o`=0 and `busy_o`=0.
- IDLE, `step_i`=1, `spike_i`≠0: load `pending_r`←`spike_i` and go to DRAIN.
- IDLE, `step_i`=1, `spike_i`=0: stay in IDLE and pulse `step_done_o` next cycle.
- Grant (combinational from registers): the lowest index g with `pending_r[g]`=1, searching circularly from `ptr_r` upward with wrap NUM_NEURONS-1→0.
- `aer_valid_o` = (state==DRAIN). `aer_addr_o` = g in DRAIN, 0 otherwise.
- Handshake is `aer_valid_o && aer_ready_i`. On a handshake:
  - clear `pending_r[g]`;
  - `ptr_r` ← (g+1) mod NUM_NEURONS, wrapping to 0 when g = NUM_NEURONS-1, including non-power-of-2 sizes.
- Handshake that clears the last pending bit: go to IDLE and pulse `step_done_o` next cycle.
- Without `aer_ready_i`: `aer_addr_o` and `aer_valid_o` hold stable. Valid never drops before acceptance.
- `step_i` while in DRAIN: ignored, `pending_r` is unchanged, `overrun_o` pulses next cycle. This includes the cycle of the final handshake, because the state is still DRAIN.
- `spike_i` is sampled only on `step_i` in IDLE; changes at any other time have no effect.
- `ptr_r` persists across steps, so fairness spans timesteps.
- `rst_ni` low mid-drain: pending spikes are discarded, outputs drop immediately (async), and no `step_done_o` is produced.

## Timing
- `step_i` at cycle t (IDLE, spikes present): `aer_valid_o`=1 from cycle t+1.
- Throughput: one address per cycle while `aer_ready_i` is held high.
- k captured spikes with ready always high: handshakes at t+1…t+k, IDLE and `step_done_o`=1 at t+k+1.
- Empty step at t: `step_done_o` at t+1, `busy_o` never asserts.
- Earliest accepted new `step_i` is the cycle `step_done_o` is high (state is IDLE).
- `step_done_o` and `overrun_o` are registered, with exactly one-cycle pulses.

## Structure
- A shared package `snn_pkg` holds:
  - the FSM state enum type `arb_state_e` {IDLE, DRAIN};
  - the default neuron count constant `SNN_NUM_NEURONS`;
  - `aer_addr_t` sized from that constant, for use by neighbouring blocks.
- One sub-module, `rr_pick`: purely combinational circular priority encoder. Inputs are the request vector and the pointer; outputs are the grant index and any-request. It is parameterised by NUM_NEURONS.
- The top module holds the FSM, `pending_r`, `ptr_r` and the pulse registers.

## Test plan
- Reset, then `step_i` with `spike_i`=16'h0000: `step_done_o` pulses 1 cycle later; `aer_valid_o` and `busy_o` stay 0.
- `ptr_r`=0, `spike_i`=16'h8421, ready always 1: addresses 0,5,10,15 on consecutive cycles; `step_done_o` on the 5th cycle after the step.
- Fairness: step 1 with 16'h0003 drains 0,1 and leaves `ptr_r`=2. Step 2 with 16'h0005 drains 2 then 0, wrapping.
- Backpressure: `spike_i`=16'h0030, ready low 3 cycles, then high. `aer_addr_o`=4 held stable with valid high for 3 cycles, then 4,5.
- `step_i` during DRAIN, including the final-handshake cycle: `overrun_o` pulses 1 cycle later; drained addresses match the original capture only.
- `rst_ni` asserted mid-drain with 16'hFFFF: valid drops asynchronously; after release the FSM is in IDLE with `ptr_r`=0 and no `step_done_o` pulse.
